// File: rtl/ps2_command_sender.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues a start bit,
// shifts a byte plus odd parity out on device clock falls and checks the device ACK.
module ps2_command_sender #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_command,
    input  logic [7:0] the_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_WAIT_FIRST = 3'd2,
        ST_SEND       = 3'd3,
        ST_WAIT_ACK   = 3'd4,
        ST_WAIT_IDLE  = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [8:0]       shift_q, shift_d;
    logic             clk_drive_q, clk_drive_d;
    logic             dat_drive_q, dat_drive_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;
    logic             err_q, err_d;
    logic             clk_meta_q, clk_meta_d;
    logic             clk_s_q, clk_s_d;
    logic             clk_last_q, clk_last_d;
    logic             dat_meta_q, dat_meta_d;
    logic             dat_s_q, dat_s_d;
    logic             fall_s;
    logic             fail_now;

    assign fall_s = clk_last_q & ~clk_s_q;

    // Next-state, counter, shift and output computation
    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_s_d     = clk_meta_q;
        clk_last_d  = clk_s_q;
        dat_meta_d  = ps2_dat_in;
        dat_s_d     = dat_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        clk_drive_d = clk_drive_q;
        dat_drive_d = dat_drive_q;
        busy_d      = busy_q;
        sent_d      = 1'b0;
        err_d       = 1'b0;
        fail_now    = 1'b0;

        case (state_q)
            // FAIL already reports busy=0, so it accepts a new request like IDLE
            ST_IDLE, ST_FAIL: begin
                if (send_command) begin
                    state_d     = ST_INHIBIT;
                    busy_d      = 1'b1;
                    clk_drive_d = 1'b1;
                    dat_drive_d = 1'b0;
                    cnt_d       = '0;
                    bitcnt_d    = 4'd0;
                    shift_d     = {odd_parity(the_command), the_command};
                end else begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    clk_drive_d = 1'b0;
                    dat_drive_d = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    clk_drive_d = 1'b0;
                    dat_drive_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_FIRST: begin
                if (fall_s) begin
                    dat_drive_d = ~shift_q[0];
                    shift_d     = {1'b0, shift_q[8:1]};
                    bitcnt_d    = 4'd1;
                    cnt_d       = '0;
                    state_d     = ST_SEND;
                end else if (cnt_q >= START_LAST) begin
                    fail_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SEND: begin
                if (fall_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (bitcnt_q == 4'd9) begin
                        dat_drive_d = 1'b0;
                        state_d     = ST_WAIT_ACK;
                    end else begin
                        dat_drive_d = ~shift_q[0];
                        shift_d     = {1'b0, shift_q[8:1]};
                        bitcnt_d    = bitcnt_q + 4'd1;
                    end
                end else if (cnt_q >= XFER_LAST) begin
                    fail_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_ACK: begin
                if (fall_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!dat_s_q) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        fail_now = 1'b1;
                    end
                end else if (cnt_q >= XFER_LAST) begin
                    fail_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s_q && dat_s_q) begin
                    sent_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    bitcnt_d = 4'd0;
                    state_d  = ST_IDLE;
                end else if (cnt_q >= XFER_LAST) begin
                    fail_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                clk_drive_d = 1'b0;
                dat_drive_d = 1'b0;
            end
        endcase

        if (fail_now) begin
            state_d     = ST_FAIL;
            err_d       = 1'b1;
            busy_d      = 1'b0;
            clk_drive_d = 1'b0;
            dat_drive_d = 1'b0;
            cnt_d       = '0;
            bitcnt_d    = 4'd0;
            shift_d     = 9'd0;
        end else begin
            err_d = 1'b0;
        end
    end

    // State, synchroniser and registered-output flops with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= 4'd0;
            shift_q     <= 9'd0;
            clk_drive_q <= 1'b0;
            dat_drive_q <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_meta_q  <= 1'b1;
            clk_s_q     <= 1'b1;
            clk_last_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_s_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            clk_drive_q <= clk_drive_d;
            dat_drive_q <= dat_drive_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            err_q       <= err_d;
            clk_meta_q  <= clk_meta_d;
            clk_s_q     <= clk_s_d;
            clk_last_q  <= clk_last_d;
            dat_meta_q  <= dat_meta_d;
            dat_s_q     <= dat_s_d;
        end
    end

    assign ps2_clk_drive_low             = clk_drive_q;
    assign ps2_dat_drive_low             = dat_drive_q;
    assign busy                          = busy_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;

endmodule

// File: doc/ps2_command_sender.md
Name: ps2_command_sender

Overview:
- PS/2 host-to-device transmitter. It is the sending side of the keyboard link whose receiving side is PS2_Controller.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Protocol: inhibit the clock, send the start bit, shift the byte out on device-generated clock edges, then check the device ACK.
- Sits beside PS2_Controller in the top level. Top level drives the pads open-drain: PS2_CLK = ps2_clk_drive_low ? 0 : z, and PS2_DAT likewise.

Parameters:
INHIBIT_CYCLES, 5000, cycles PS2_CLK is held low before the start bit (100 us at 50 MHz)
START_TIMEOUT, 750000, max cycles from CLK release to the first device falling edge (15 ms)
XFER_TIMEOUT, 100000, max cycles from the first falling edge to line release after ACK (2 ms)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
send_command  input  1  one-cycle request; accepted only when busy=0
the_command  input  8  byte to send; latched on the cycle send_command is accepted
ps2_clk_in  input  1  PS2_CLK pad value (asynchronous)
ps2_dat_in  input  1  PS2_DAT pad value (asynchronous)
ps2_clk_drive_low  output  1  1 = pull PS2_CLK low
ps2_dat_drive_low  output  1  1 = pull PS2_DAT low
busy  output  1  high from accept until return to IDLE
command_was_sent  output  1  one-cycle pulse on successful, ACKed transfer
error_communication_timed_out  output  1  one-cycle pulse on timeout or missing ACK

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and shift register cleared, sync flops set to 1. Reset mid-operation releases both lines the next cycle with no pulse. Reset wins over a same-cycle send_command.
- Input sync: each pad goes through two flops to give clk_s and dat_s. fall = clk_s_d & ~clk_s. Actions on a fall are registered, so outputs change 3 cycles after the pad edge.
- Latch on accept: shift = {odd parity = ~^the_command, the_command}, 9 bits, LSB first. send_command while busy=1 is ignored.
- IDLE: on send_command, go to INHIBIT; busy=1, clk_drive_low=1, counter=0.
- INHIBIT: count INHIBIT_CYCLES cycles, clk_drive_low held exactly INHIBIT_CYCLES cycles. On the last count set dat_drive_low=1 (start bit) and, the same cycle, clk_drive_low=0; go to WAIT_FIRST.
- WAIT_FIRST: on the first fall, drive bit0 (dat_drive_low = ~bit), bitcnt=1, go to SEND. If START_TIMEOUT cycles elapse with no fall, go to FAIL.
- SEND: on each fall, drive the next shift bit.
  - Falls 1-8: data bits 0-7.
  - Fall 9: parity bit.
  - Fall 10: dat_drive_low=0 (stop bit, line released); go to WAIT_ACK.
- WAIT_ACK: on fall 11, sample dat_s. If 0 (ACK), go to WAIT_IDLE; if 1, go to FAIL.
- WAIT_IDLE: when clk_s=1 and dat_s=1 in the same cycle, pulse command_was_sent and go to IDLE with busy=0 in that same cycle.
- XFER_TIMEOUT: counter starts at fall 1 and runs through SEND, WAIT_ACK and WAIT_IDLE. Reaching the limit goes to FAIL.
- Edge vs timeout: if a fall coincides with the timeout's final cycle, the fall is processed and the timeout is not.
- FAIL: one cycle. Release both lines, pulse error_communication_timed_out, busy=0, go to IDLE.
- command_was_sent and error_communication_timed_out are never both high, and each is exactly one cycle.
- Lines are never both driven low during INHIBIT. ps2_dat_drive_low changes only on fall cycles, except the start-bit assertion.

Test Plan:
(Sim parameters: INHIBIT_CYCLES=8, START_TIMEOUT=200, XFER_TIMEOUT=2000. Device model generates a 40-cycle-period clock 20 cycles after CLK release.)
- Send 0xED, device ACKs:
  - clk_drive_low high exactly 8 cycles.
  - Released data at falls 1-9 reads 1,0,1,1,0,1,1,1 then parity 1.
  - One command_was_sent pulse after both lines are high; busy falls the same cycle.
- Send 0x01: device-sampled bits are 1,0,0,0,0,0,0,0 with parity 0; command_was_sent pulses.
- Send 0xF4, device never clocks: error_communication_timed_out pulses 200 cycles after CLK release; both drive outputs 0; busy=0.
- Send 0xFF, device leaves DAT high at fall 11: error pulse; no command_was_sent.
- send_command with 0xAA pulsed during the 0xED transfer: ignored, device receives 0xED. A later 0xAA request after busy=0 is sent correctly.
- reset asserted after fall 5 of a transfer: next cycle both drive outputs 0 and busy=0; no pulses ever occur.
